// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter in front of a single byte-serial UART transmitter.
// An owner keeps the transmitter for a whole packet, which ends with req_last. Each packet
// can be prefixed with a source-ID header byte. A packet that stalls too long is aborted.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter bit          HDR_EN      = 1'b1,
    parameter logic [4:0]  HDR_TAG     = 5'b10100,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned TO_W        = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [2:0]           grant_id,
    output logic                 pkt_active,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {StIdle, StHdr, StData, StStart, StDrain} arbStateT;

    arbStateT        state;
    logic [2:0]      lastGrant;
    logic            hdrPhase;
    logic            lastFlag;
    logic [TO_W-1:0] toCnt;

    logic            selValid;
    logic            selLast;
    logic [7:0]      selData;
    logic            pickFound;
    logic [2:0]      pickId;
    logic            handshake;
    logic            toFire;

    // Mux the current owner's byte stream out of the flat request buses
    always_comb begin
        selValid = 1'b0;
        selLast  = 1'b0;
        selData  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id == 3'(i)) begin
                selValid = req_valid[i];
                selLast  = req_last[i];
                selData  = req_data[8*i +: 8];
            end
        end
    end

    // Only the owner sees ready, and only while no byte is in flight
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready[i] = (state == StData) && !tx_busy && (grant_id == 3'(i));
        end
    end

    // Round-robin pick: first valid requester after lastGrant, wrapping around
    always_comb begin
        int idx;
        pickFound = 1'b0;
        pickId    = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = (int'(lastGrant) + k) % int'(NUM_REQ);
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!pickFound && (j == idx) && req_valid[j]) begin
                    pickFound = 1'b1;
                    pickId    = 3'(j);
                end
            end
        end
    end

    // Handshake beats the timeout when both land in the same cycle
    always_comb begin
        handshake = (state == StData) && !tx_busy && selValid;
        toFire    = (TIMEOUT_CYC != 0) && (state == StData) && !handshake &&
                    (toCnt == TO_W'(TIMEOUT_CYC - 1));
    end

    // Packet sequencer with registered transmitter-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            lastGrant   <= 3'(NUM_REQ - 1);
            hdrPhase    <= 1'b0;
            lastFlag    <= 1'b0;
            toCnt       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            pkt_active  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    toCnt <= '0;
                    if (pickFound) begin
                        grant_id   <= pickId;
                        pkt_active <= 1'b1;
                        state      <= HDR_EN ? StHdr : StData;
                    end
                end
                StHdr: begin
                    if (!tx_busy) begin
                        tx_data  <= {HDR_TAG, grant_id};
                        tx_start <= 1'b1;
                        hdrPhase <= 1'b1;
                        state    <= StStart;
                    end
                end
                StData: begin
                    if (handshake) begin
                        tx_data  <= selData;
                        tx_start <= 1'b1;
                        lastFlag <= selLast;
                        state    <= StStart;
                    end else if (toFire) begin
                        timeout_err <= 1'b1;
                        lastGrant   <= grant_id;
                        pkt_active  <= 1'b0;
                        state       <= StIdle;
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                StStart: begin
                    // Transmitter raises busy on this edge; DRAIN then waits it out
                    state <= StDrain;
                end
                StDrain: begin
                    // Cleared here so every entry into DATA starts a fresh timeout window
                    toCnt <= '0;
                    if (!tx_busy) begin
                        if (hdrPhase) begin
                            hdrPhase <= 1'b0;
                            state    <= StData;
                        end else if (lastFlag) begin
                            lastGrant  <= grant_id;
                            pkt_active <= 1'b0;
                            state      <= StIdle;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table-driven fairness rounds plus hand-written
// sequences for single packet, no-preemption, timeout and reset mid-frame.
module tb_uart_tx_arbiter;

    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        pkt_active;
    logic        timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .HDR_EN(1'b1),
        .HDR_TAG(5'b10100),
        .TIMEOUT_CYC(16),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .pkt_active(pkt_active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for FRAME cycles starting the edge after tx_start
    int busyCnt = 0;
    always @(posedge clk) begin
        if (tx_start) busyCnt <= FRAME;
        else if (busyCnt != 0) busyCnt <= busyCnt - 1;
    end
    assign tx_busy = (busyCnt != 0);

    // Monitor: log launched bytes, count starts during busy and abort pulses
    logic [7:0] txLog [256];
    int txCnt = 0;
    int overlapCnt = 0;
    int toPulses = 0;
    always @(posedge clk) begin
        if (tx_start) begin
            txLog[txCnt] <= tx_data;
            txCnt <= txCnt + 1;
            if (tx_busy) overlapCnt <= overlapCnt + 1;
        end
        if (timeout_err) toPulses <= toPulses + 1;
    end

    // Requester model: per-requester FIFO of {last, data}
    logic [8:0] mem [4][32];
    int head [4] = '{0, 0, 0, 0};
    int tail [4] = '{0, 0, 0, 0};

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) head[i] = head[i] + 1;
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                req_valid[i]       = (head[i] != tail[i]);
                req_data[8*i +: 8] = mem[i][head[i] % 32][7:0];
                req_last[i]        = mem[i][head[i] % 32][8];
            end
        end
    end

    int passCnt = 0;
    int totalCnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passCnt++;
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic last);
        mem[id][tail[id] % 32] = {last, d};
        tail[id] = tail[id] + 1;
    endtask

    function automatic bit anyPending();
        for (int i = 0; i < 4; i++) if (head[i] != tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic waitDone(input string name);
        int n = 0;
        while ((anyPending() || pkt_active || tx_busy) && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        chk(name, 32'(n < 3000), 1);
    endtask

    task automatic waitTx(input int target);
        int n = 0;
        while (txCnt < target && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("tx_wait", 32'(txCnt >= target), 1);
    endtask

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][2:0] order;
    } round_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passCnt, totalCnt);
        $fatal(1);
    end

    initial begin
        round_t rounds [5];
        logic [7:0] expNp [10];
        logic [2:0] id;
        int base;
        int n;

        // Expected grant orders, carried across rounds from lastGrant=3 after reset
        rounds[0] = '{mask: 4'b1111, n: 3'd4, order: {3'd3, 3'd2, 3'd1, 3'd0}};
        rounds[1] = '{mask: 4'b0101, n: 3'd2, order: {3'd0, 3'd0, 3'd2, 3'd0}};
        rounds[2] = '{mask: 4'b1011, n: 3'd3, order: {3'd0, 3'd1, 3'd0, 3'd3}};
        rounds[3] = '{mask: 4'b0001, n: 3'd1, order: {3'd0, 3'd0, 3'd0, 3'd0}};
        rounds[4] = '{mask: 4'b1110, n: 3'd3, order: {3'd0, 3'd3, 3'd2, 3'd1}};

        // Reset state
        #12;
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_pkt_active", 32'(pkt_active), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Fairness rounds: single-byte packets, data = 16*(id+1)+round
        for (int r = 0; r < 5; r++) begin
            base = txCnt;
            for (int i = 0; i < 4; i++) begin
                if (rounds[r].mask[i]) push(i, 8'((i + 1) * 16 + r), 1'b1);
            end
            waitDone("round_done");
            chk("round_bytes", 32'(txCnt - base), 32'(2 * int'(rounds[r].n)));
            for (int j = 0; j < int'(rounds[r].n); j++) begin
                id = rounds[r].order[j];
                chk("round_hdr", 32'(txLog[base + 2*j]), 32'({5'b10100, id}));
                chk("round_data", 32'(txLog[base + 2*j + 1]), 32'((int'(id) + 1) * 16 + r));
            end
        end

        // Single packet from requester 2, with grant and header latency
        base = txCnt;
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("grant_pkt_active", 32'(pkt_active), 1);
        chk("grant_id_2", 32'(grant_id), 2);
        @(posedge clk); #2;
        chk("hdr_start", 32'(tx_start), 1);
        chk("hdr_data", 32'(tx_data), 32'h A2);
        waitDone("single_done");
        chk("single_count", 32'(txCnt - base), 3);
        chk("single_b0", 32'(txLog[base]), 32'h A2);
        chk("single_b1", 32'(txLog[base + 1]), 32'h 11);
        chk("single_b2", 32'(txLog[base + 2]), 32'h 22);

        // No preemption: requester 1 five-byte packet, 0 and 3 arrive mid-packet
        base = txCnt;
        for (int b = 0; b < 5; b++) push(1, 8'(8'h51 + b), b == 4);
        waitTx(base + 3);
        push(0, 8'h0E, 1'b1);
        push(3, 8'h3E, 1'b1);
        waitDone("nopre_done");
        expNp = '{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'hA3, 8'h3E, 8'hA0, 8'h0E};
        chk("nopre_count", 32'(txCnt - base), 10);
        for (int j = 0; j < 10; j++) chk("nopre_byte", 32'(txLog[base + j]), 32'(expNp[j]));

        // Timeout: one non-last byte from requester 3, then silence
        base = txCnt;
        push(3, 8'h77, 1'b0);
        waitTx(base + 2);
        n = 0;
        while (!req_ready[3] && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("to_data_entry", 32'(req_ready[3]), 1);
        n = 0;
        while (!timeout_err && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        chk("to_latency", 32'(n), 16);
        chk("to_pkt_active", 32'(pkt_active), 0);
        @(posedge clk); #2;
        chk("to_one_pulse", 32'(timeout_err), 0);
        repeat (30) @(posedge clk);
        #2;
        chk("to_no_more_tx", 32'(txCnt - base), 2);
        chk("to_pulse_count", 32'(toPulses), 1);
        base = txCnt;
        push(2, 8'h2B, 1'b1);
        push(0, 8'h0B, 1'b1);
        waitDone("after_to_done");
        chk("after_to_hdr0", 32'(txLog[base]), 32'h A0);
        chk("after_to_dat0", 32'(txLog[base + 1]), 32'h 0B);
        chk("after_to_hdr1", 32'(txLog[base + 2]), 32'h A2);

        // Reset during DRAIN while the transmitter is mid-frame
        base = txCnt;
        push(2, 8'h61, 1'b0);
        push(2, 8'h62, 1'b1);
        waitTx(base + 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_outputs", 32'({tx_start, tx_data, req_ready, grant_id, timeout_err}), 0);
        chk("arst_pkt_active", 32'(pkt_active), 0);
        chk("arst_busy_still", 32'(tx_busy), 1);
        for (int i = 0; i < 4; i++) tail[i] = head[i];
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = txCnt;
        push(1, 8'h71, 1'b1);
        push(0, 8'h70, 1'b1);
        waitDone("post_rst_done");
        chk("post_rst_hdr0", 32'(txLog[base]), 32'h A0);
        chk("post_rst_dat0", 32'(txLog[base + 1]), 32'h 70);
        chk("post_rst_hdr1", 32'(txLog[base + 2]), 32'h A1);
        chk("post_rst_dat1", 32'(txLog[base + 3]), 32'h 71);

        chk("start_vs_busy", 32'(overlapCnt), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares one `async_transmitter` among `NUM_REQ` byte-stream requesters, such as the command responder, ADC status reporter and debug dump.
- It grants the UART to one requester for a whole packet, delimited by `req_last`.
- When `HDR_EN`=1, it prefixes each packet with a source-ID header byte.
- It sequences every byte through the transmitter's start/busy handshake.
- It aborts a stalled packet after a programmable timeout.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `HDR_EN`, 1: when 1, send a header byte `{HDR_TAG, id[2:0]}` before each packet.
- `HDR_TAG`, 5'b10100: upper 5 bits of the header byte. With the default, header = 0xA0 | id.
- `TIMEOUT_CYC`, 1000000: maximum number of `clk` cycles spent waiting for the next byte of a granted packet. 0 disables the timeout.
- `TO_W`, 24: width of the timeout counter. Requires `TIMEOUT_CYC` < 2^`TO_W`.

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, `NUM_REQ`: per-requester byte valid.
- `req_data`, input, 8*`NUM_REQ`: requester i uses bits [8i+7:8i].
- `req_last`, input, `NUM_REQ`: byte is the final byte of its packet. Qualified by valid.
- `req_ready`, output, `NUM_REQ`: byte accepted in any cycle where `req_valid[i]` & `req_ready[i]`.
- `tx_start`, output, 1: one-cycle pulse to the transmitter's `TxD_start`.
- `tx_data`, output, 8: byte for the transmitter's `TxD_data`. Valid while `tx_start`=1.
- `tx_busy`, input, 1: the transmitter's `TxD_busy`.
- `grant_id`, output, 3: index of the current owner. Meaningful while `pkt_active`=1.
- `pkt_active`, output, 1: high from grant until the end of the packet or an abort.
- `timeout_err`, output, 1: one-cycle pulse when a packet is aborted.

## Operation
States:
- IDLE
- HDR: launch the header byte.
- DATA: wait for a requester byte.
- START: `tx_start` asserted.
- DRAIN: wait for the transmitter to go idle.

Transitions:
- **IDLE**
  - If any `req_valid` is high, select the first set bit searching from (`last_grant`+1) mod `NUM_REQ` upward with wrap-around.
  - Register the result into `grant_id` and set `pkt_active`.
  - Next state is HDR if `HDR_EN`=1, else DATA.
- **HDR**
  - When `tx_busy`=0: register `tx_data` = {HDR_TAG, grant_id}, set `tx_start`=1 and `hdr_phase`=1, then go to START.
- **DATA**
  - `req_ready[grant_id]` = (state==DATA) & ~`tx_busy`. This is combinational. All other `req_ready` bits are 0.
  - On handshake: register `tx_data` = the requester's byte, set `tx_start`=1, latch `last_flag` = `req_last[grant_id]`, then go to START.
- **START**
  - `tx_start` is high for exactly this one cycle.
  - The next state is always DRAIN. The transmitter raises `tx_busy` on the following edge.
- **DRAIN**
  - When `tx_busy`=0:
    - If `hdr_phase`: clear `hdr_phase` and go to DATA.
    - Else if `last_flag`: `last_grant` <= `grant_id`, clear `pkt_active`, go to IDLE.
    - Else go to DATA.
- **Timeout**
  - The counter clears on every entry to DATA and increments each cycle spent in DATA without a handshake.
  - On reaching `TIMEOUT_CYC`-1 with no handshake that cycle:
    - pulse `timeout_err`;
    - set `last_grant` <= `grant_id`;
    - clear `pkt_active`;
    - go to IDLE.
  - No byte is sent for the aborted packet.
  - A handshake and the timeout occurring in the same cycle: the handshake wins.
- **Arbitration scope**
  - Requests from non-owners are ignored until the owner's packet completes or aborts. There is no preemption.
  - A single-byte packet (`req_last`=1 on the first byte) is legal.

Reset values:
- Outputs: `tx_start`=0, `tx_data`=0, `req_ready`=0, `grant_id`=0, `pkt_active`=0, `timeout_err`=0.
- Internal: state=IDLE, `last_grant`=`NUM_REQ`-1 (requester 0 has first priority), `hdr_phase`=0, `last_flag`=0, timeout counter=0.

## Timing
- **Grant latency:** `req_valid` seen in IDLE at cycle t gives `pkt_active`=1 at t+1.
  - With `HDR_EN`=1 and the transmitter idle: header `tx_start` at t+2.
  - With `HDR_EN`=0: `req_ready` is high at t+1, and `tx_start` follows at t+2 if valid.
- **Byte launch:** a handshake at cycle t gives `tx_start`=1 with `tx_data` at t+1, and DRAIN from t+2.
- **Transmitter contract:** `tx_start` is never asserted while `tx_busy`=1. At most one byte is in flight. The data bus is stable during the `tx_start` cycle.
- **Back-to-back bytes:** the minimum spacing is one transmitter frame plus 3 `clk` cycles.
- **Between packets:** after DRAIN finishes with `last_flag`, there is 1 IDLE cycle before the next grant.
- **Reset mid-frame:** outputs clear immediately. The transmitter may still be busy, so HDR and DATA gate on ~`tx_busy` and no start overlaps the ongoing frame.
- **Timeout arithmetic:** the abort pulse occurs exactly `TIMEOUT_CYC` cycles after DATA entry. With `TIMEOUT_CYC`=0 the counter never fires.

## Test plan
- **Single packet:** `NUM_REQ`=4, `HDR_EN`=1, `SIMULATION`-mode transmitter. Requester 2 sends 0x11, 0x22 (last) -> `tx_data` sequence 0xA2, 0x11, 0x22. Exactly 3 `tx_start` pulses. `pkt_active` falls after the final DRAIN.
- **Fairness:** all 4 requesters continuously valid with 1-byte packets -> grant order 0, 1, 2, 3, 0, … Headers read 0xA0, 0xA1, 0xA2, 0xA3.
- **No preemption:** requester 1 holds a 5-byte packet while requester 0 asserts valid mid-packet -> all 5 bytes from requester 1 are contiguous, then requester 2 or 3 if pending, otherwise 0.
- **Timeout:** `TIMEOUT_CYC`=16; requester 3 sends one non-last byte then drops valid -> `timeout_err` pulses 16 cycles after DATA entry. No further `tx_start` pulses. The next grant goes to requester 0.
- **Busy compliance:** real transmitter at 921600 baud; random valid gaps -> `tx_start` is never coincident with `tx_busy`=1, and the bytes decoded on TxD match the input stream.
- **Reset mid-packet:** `rst_n` low during DRAIN -> all outputs go to 0 asynchronously. After release, requester 0 is granted first, and the first `tx_start` waits for `tx_busy`=0.
